// File: rtl/regfile_pkg.sv
// Shared types and field constants for the register file write-back path.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;
  localparam int unsigned RD_HI = 15;
  localparam int unsigned RD_LO = 11;

  localparam logic DEST_IMM = 1'b0;
  localparam logic DEST_REG = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;

  function automatic logic [REG_ADDR_W-1:0] decode_dest(input logic [31:0] instr,
                                                        input logic       fmt);
    return (fmt == DEST_REG) ? instr[RD_HI:RD_LO] : instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/wbq_match.sv
// Age-ordered forwarding search over the write-back queue and its output register.
module wbq_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [REG_ADDR_W-1:0]  addr,
  input  wbq_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       head,
  input  logic                   out_we,
  input  wbq_entry_t             out_entry,
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (addr != '0) begin
      if (out_we && (out_entry.dest == addr)) begin
        hit  = 1'b1;
        data = out_entry.data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if (valid[idx] && (entries[idx].dest == addr)) begin
          hit  = 1'b1;
          data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue feeding the register file write port, with forwarding.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instruction,
  input  logic                  in_destination,
  input  logic                  in_write,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  wb_ready,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  input  logic [REG_ADDR_W-1:0] q_rs_addr,
  input  logic [REG_ADDR_W-1:0] q_rt_addr,
  output logic                  q_rs_hit,
  output logic [DATA_W-1:0]     q_rs_data,
  output logic                  q_rt_hit,
  output logic [DATA_W-1:0]     q_rt_data,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0]   FullCount = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CountOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  wbq_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [PTR_W:0]         count_q;
  wbq_entry_t             out_q;
  logic                   wb_we_q;

  logic [REG_ADDR_W-1:0] in_dest;
  logic                  accept, store, pop;

  assign in_ready = (count_q < FullCount);
  assign in_dest  = decode_dest(in_instruction, in_destination);
  assign accept   = in_valid & in_ready;
  // Non-writing results and writes to r0 complete the handshake but take no slot.
  assign store    = accept & in_write & (in_dest != '0);
  assign pop      = wb_ready & (count_q != '0);

  always_comb begin
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (store) begin
      valid_d[tail_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      wb_we_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (store) begin
        tail_q <= tail_q + PtrOne;
      end
      if (pop) begin
        head_q <= head_q + PtrOne;
      end
      if (store && !pop) begin
        count_q <= count_q + CountOne;
      end else if (!store && pop) begin
        count_q <= count_q - CountOne;
      end
      wb_we_q <= pop;
      if (pop) begin
        out_q <= mem_q[head_q];
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[tail_q] <= '{dest: in_dest, data: in_data};
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = out_q.dest;
  assign wb_data = out_q.data;
  assign count   = count_q;

  wbq_match #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_match_rs (
    .addr     (q_rs_addr),
    .entries  (mem_q),
    .valid    (valid_q),
    .head     (head_q),
    .out_we   (wb_we_q),
    .out_entry(out_q),
    .hit      (q_rs_hit),
    .data     (q_rs_data)
  );

  wbq_match #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_match_rt (
    .addr     (q_rt_addr),
    .entries  (mem_q),
    .valid    (valid_q),
    .head     (head_q),
    .out_we   (wb_we_q),
    .out_entry(out_q),
    .hit      (q_rt_hit),
    .data     (q_rt_data)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench: pending-write list model, negedge monitor for writes and forwarding.
module tb_regfile_writeback_queue;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic        in_destination;
  logic        in_write;
  logic [31:0] in_data;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  q_rs_addr;
  logic [4:0]  q_rt_addr;
  logic        q_rs_hit;
  logic [31:0] q_rs_data;
  logic        q_rt_hit;
  logic [31:0] q_rt_data;
  logic [2:0]  count;

  int   n_checks;
  int   n_errors;
  bit   mon_en;
  ent_t pend[$];  // accepted stores not yet committed to the register file, oldest first

  regfile_writeback_queue #(
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instruction(in_instruction),
    .in_destination(in_destination),
    .in_write      (in_write),
    .in_data       (in_data),
    .wb_ready      (wb_ready),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .q_rs_addr     (q_rs_addr),
    .q_rt_addr     (q_rt_addr),
    .q_rs_hit      (q_rs_hit),
    .q_rs_data     (q_rs_data),
    .q_rt_hit      (q_rt_hit),
    .q_rt_data     (q_rt_data),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].dest == a) begin
          h = 1'b1;
          d = pend[i].data;
          break;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic        eh;
      logic [31:0] ed;
      model_fwd(q_rs_addr, eh, ed);
      check("rs_hit", q_rs_hit, eh);
      check("rs_data", q_rs_data, ed);
      model_fwd(q_rt_addr, eh, ed);
      check("rt_hit", q_rt_hit, eh);
      check("rt_data", q_rt_data, ed);
      check("count_bound", (count <= 3'd4), 1);
      if (wb_we === 1'b1) begin
        if (pend.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("wb_addr", wb_addr, pend[0].dest);
          check("wb_data", wb_data, pend[0].data);
          void'(pend.pop_front());
        end
      end else begin
        check("wb_we_known", wb_we, 0);
      end
    end
  end

  // One clock: drive at posedge+1, note acceptance, record model effect at the edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic fmt,
                      input logic w, input logic [31:0] d, input logic rdy);
    logic       snap;
    logic [4:0] dst;
    in_valid       = v;
    in_instruction = instr;
    in_destination = fmt;
    in_write       = w;
    in_data        = d;
    wb_ready       = rdy;
    @(negedge clk);
    snap = v && (in_ready === 1'b1);
    @(posedge clk);
    dst = fmt ? instr[15:11] : instr[20:16];
    if (snap && w && (dst != 5'd0)) pend.push_back('{dest: dst, data: d});
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  task automatic push_rt(input logic [4:0] r, input logic [31:0] d, input logic rdy);
    logic [31:0] instr;
    instr = 32'h0;
    instr[20:16] = r;
    step(1'b1, instr, 1'b0, 1'b1, d, rdy);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    pend.delete();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int we_cycles;
    int guard;
    n_checks = 0;
    n_errors = 0;
    mon_en   = 0;
    rst = 1'b1;
    in_valid = 0; in_instruction = 0; in_destination = 0; in_write = 0; in_data = 0;
    wb_ready = 0; q_rs_addr = 0; q_rt_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;
    check("rst_count", count, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_in_ready", in_ready, 1);

    // Single result, latency
    q_rs_addr = 5'd8;
    step(1'b1, 32'h2008_0005, 1'b0, 1'b1, 32'h5, 1'b1);
    check("t1_we_not_yet", wb_we, 0);
    check("t1_count1", count, 1);
    idle(1'b1);
    check("t1_we", wb_we, 1);
    check("t1_addr", wb_addr, 8);
    check("t1_data", wb_data, 5);
    check("t1_count0", count, 0);
    idle(1'b1);
    check("t1_we_drop", wb_we, 0);

    // Fill, backpressure, ordered drain
    for (int r = 1; r <= 4; r++) push_rt(5'(r), 32'h100 + r, 1'b0);
    check("t2_full_count", count, 4);
    check("t2_not_ready", in_ready, 0);
    push_rt(5'd5, 32'h105, 1'b0);
    check("t2_fifth_rejected", count, 4);
    for (int r = 1; r <= 4; r++) begin
      idle(1'b1);
      check("t2_drain_we", wb_we, 1);
      check("t2_drain_addr", wb_addr, r);
    end
    check("t2_empty", count, 0);
    idle(1'b1);

    // Youngest-match forwarding
    q_rs_addr = 5'd9;
    push_rt(5'd9, 32'hAA, 1'b0);
    push_rt(5'd9, 32'hBB, 1'b0);
    check("t3_hit", q_rs_hit, 1);
    check("t3_data", q_rs_data, 32'hBB);
    repeat (3) idle(1'b1);
    check("t3_miss", q_rs_hit, 0);
    check("t3_miss_data", q_rs_data, 0);

    // r0 destination and non-writing result are consumed but not stored
    q_rt_addr = 5'd0;
    step(1'b1, 32'h0003_0000, 1'b1, 1'b1, 32'h77, 1'b1);
    check("t4_r0_count", count, 0);
    step(1'b1, 32'h0005_0000, 1'b0, 1'b0, 32'h88, 1'b1);
    check("t4_nowrite_count", count, 0);
    idle(1'b1);
    check("t4_no_we", wb_we, 0);
    check("t4_rt0_miss", q_rt_hit, 0);

    // Full queue, streaming across pointer wrap
    for (int r = 10; r <= 13; r++) push_rt(5'(r), 32'h200 + r, 1'b0);
    we_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      push_rt(5'($urandom_range(1, 31)), $urandom, 1'b1);
      if (wb_we === 1'b1) we_cycles++;
    end
    check("t5_throughput", we_cycles, 8);
    repeat (6) idle(1'b1);

    // Reset mid-operation
    q_rs_addr = 5'd20;
    push_rt(5'd20, 32'h300, 1'b0);
    push_rt(5'd21, 32'h301, 1'b0);
    push_rt(5'd22, 32'h302, 1'b0);
    check("t6_pre_count", count, 3);
    do_reset();
    check("t6_count", count, 0);
    check("t6_we", wb_we, 0);
    check("t6_fwd_miss", q_rs_hit, 0);
    idle(1'b1);
    check("t6_no_stale1", wb_we, 0);
    idle(1'b1);
    check("t6_no_stale2", wb_we, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] instr;
      instr = $urandom;
      instr[20:16] = 5'($urandom_range(0, 7));
      instr[15:11] = 5'($urandom_range(0, 7));
      q_rs_addr = 5'($urandom_range(0, 7));
      q_rt_addr = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), instr, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) != 0), $urandom, ($urandom_range(0, 9) < 7));
    end

    guard = 0;
    while (pend.size() != 0 && guard < 50) begin
      idle(1'b1);
      guard++;
    end
    check("drain_done", pend.size(), 0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
